// File: rtl/ahfp_addsub_pipe.sv
// Pipelined IEEE-754 add/subtract unit with a start/done handshake. Subnormals are
// flushed to zero, rounding is round-to-nearest-even, and the latency is fixed at five enabled cycles.
module ahfp_addsub_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned LAT   = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic                     start,
   input  logic                     n,
   input  logic [EXP_W+MAN_W:0]     dataa,
   input  logic [EXP_W+MAN_W:0]     datab,
   output logic [EXP_W+MAN_W:0]     result,
   output logic                     done
);

   localparam int unsigned W       = 1 + EXP_W + MAN_W;
   localparam int unsigned M       = MAN_W + 1;          // significand incl. hidden bit
   localparam int unsigned D       = MAN_W + 5;          // carry, hidden, frac, G, R, S
   localparam int unsigned SH_MAX  = MAN_W + 3;
   localparam int unsigned XE      = EXP_W + 2;          // exponent with sign/overflow room
   localparam int unsigned LZW     = $clog2(D);
   localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

   if (LAT != 5) begin : g_bad_lat
      $error("ahfp_addsub_pipe: LAT must be 5");
   end

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // pipeline valid bits
   logic v0, v1, v2, v3, v4;

   // issue rank
   logic           n0;
   logic [W-1:0]   a0, b0;

   // S1 unpack/classify
   logic           sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge_b;
   logic [EXP_W-1:0] ea, eb;
   logic [M-1:0]   ma, mb;
   logic           spec_n;
   logic [W-1:0]   sres_n;
   logic           spec1, sign1, sub1;
   logic [W-1:0]   sres1;
   logic [EXP_W-1:0] el1, es1;
   logic [M-1:0]   ml1, ms1;

   // S2 align
   logic [EXP_W-1:0] diff;
   logic [LZW-1:0] sh;
   logic [2*D-1:0] wide;
   logic           spec2, sign2, sub2;
   logic [W-1:0]   sres2;
   logic [EXP_W-1:0] e2;
   logic [D-1:0]   l2, s2;

   // S3 add/sub
   logic           spec3, sign3;
   logic [W-1:0]   sres3;
   logic [EXP_W-1:0] e3;
   logic [D-1:0]   sum3;

   // S4 normalise
   logic [LZW-1:0] lz;
   logic [D-2:0]   norm;
   logic [XE-1:0]  en;
   logic           spec4, sign4, zero4;
   logic [W-1:0]   sres4;
   logic [XE-1:0]  e4;
   logic [D-2:0]   m4;

   // S5 round/pack
   logic           inc;
   logic [M:0]     rnd;
   logic [MAN_W-1:0] frac;
   logic [XE-1:0]  er;
   logic [W-1:0]   res_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         v4 <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else if (clk_en) begin
         v0 <= start;
         v1 <= v0;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
         done <= v4;
         if (v4) result <= res_n;
      end
   end

   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (start) begin
            a0 <= dataa;
            b0 <= datab;
            n0 <= n;
         end
         spec1 <= spec_n;  sres1 <= sres_n;
         sign1 <= a_ge_b ? sa : sb;
         sub1  <= sa ^ sb;
         el1   <= a_ge_b ? ea : eb;
         es1   <= a_ge_b ? eb : ea;
         ml1   <= a_ge_b ? ma : mb;
         ms1   <= a_ge_b ? mb : ma;
         spec2 <= spec1;  sres2 <= sres1;  sign2 <= sign1;  sub2 <= sub1;
         e2    <= el1;
         l2    <= {1'b0, ml1, 3'b000};
         s2    <= {wide[2*D-1:D+1], wide[D] | (|wide[D-1:0])};
         spec3 <= spec2;  sres3 <= sres2;  sign3 <= sign2;  e3 <= e2;
         sum3  <= sub2 ? (l2 - s2) : (l2 + s2);
         spec4 <= spec3;  sres4 <= sres3;  sign4 <= sign3;
         zero4 <= (sum3 == '0);
         e4    <= en;
         m4    <= norm;
      end
   end

   // S1: classify, flush subnormals, resolve special operands
   always_comb begin
      sa = a0[W-1];
      sb = b0[W-1] ^ n0;
      ea = a0[W-2:MAN_W];
      eb = b0[W-2:MAN_W];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_nan  = (ea == '1) && (a0[MAN_W-1:0] != '0);
      b_nan  = (eb == '1) && (b0[MAN_W-1:0] != '0);
      a_inf  = (ea == '1) && (a0[MAN_W-1:0] == '0);
      b_inf  = (eb == '1) && (b0[MAN_W-1:0] == '0);
      ma = a_zero ? '0 : {1'b1, a0[MAN_W-1:0]};
      mb = b_zero ? '0 : {1'b1, b0[MAN_W-1:0]};
      a_ge_b = ({ea, ma} >= {eb, mb});
      spec_n = 1'b1;
      sres_n = QNAN;
      if (a_nan || b_nan) begin
         sres_n = QNAN;
      end else if (a_inf && b_inf && (sa != sb)) begin
         sres_n = QNAN;
      end else if (a_inf) begin
         sres_n = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         sres_n = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         sres_n = {sa & sb, {(W-1){1'b0}}};
      end else begin
         spec_n = 1'b0;
      end
   end

   // S2: right-align the smaller operand; lost bits collapse into sticky
   always_comb begin
      diff = el1 - es1;
      sh   = (diff > EXP_W'(SH_MAX)) ? LZW'(SH_MAX) : LZW'(diff);
      wide = {1'b0, ms1, 3'b000, {D{1'b0}}} >> sh;
   end

   // S4: leading-zero count below the carry position, then normalise
   always_comb begin
      lz = LZW'(D - 1);
      for (int i = 0; i < int'(D) - 1; i++) begin
         if (sum3[i]) lz = LZW'(int'(D) - 2 - i);
      end
      if (sum3[D-1]) begin
         norm = {sum3[D-1:2], sum3[1] | sum3[0]};
         en   = {2'b00, e3} + XE'(1);
      end else begin
         norm = sum3[D-2:0] << lz;
         en   = {2'b00, e3} - XE'(lz);
      end
   end

   // S5: round to nearest even, then overflow/underflow/special selection
   always_comb begin
      inc  = m4[2] & (m4[1] | m4[0] | m4[3]);
      rnd  = {1'b0, m4[D-2:3]} + (M+1)'(inc);
      frac = rnd[M] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      er   = e4 + XE'(rnd[M]);
      if (spec4) begin
         res_n = sres4;
      end else if (zero4) begin
         res_n = '0;
      end else if (!er[XE-1] && (er >= XE'(EXP_MAX))) begin
         res_n = {sign4, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (er[XE-1] || (er == '0)) begin
         res_n = {sign4, {(W-1){1'b0}}};
      end else begin
         res_n = {sign4, er[EXP_W-1:0], frac};
      end
   end

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Directed-vector bench for ahfp_addsub_pipe (single precision): arithmetic, rounding,
// specials, stall behaviour and reset flush.
module tb_ahfp_addsub_pipe;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] r;
   } vec_t;

   logic        clk, reset, clk_en, start, n;
   logic [31:0] dataa, datab, result;
   logic        done;
   int          checks, errors;

   ahfp_addsub_pipe dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (start),
      .n      (n),
      .dataa  (dataa),
      .datab  (datab),
      .result (result),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 output logic [31:0] res, output int lat, output int nd);
      lat = -1;
      nd  = 0;
      dataa = a; datab = b; n = op; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (done === 1'b1) begin
            nd++;
            if (lat < 0) lat = i;
         end
      end
      res = result;
   endtask

   task automatic test_reset();
      reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = 1'b0; dataa = '0; datab = '0;
      tick(); tick(); tick();
      reset = 1'b0;
      checks++;
      if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
   endtask

   task automatic run_table(input string tag, input vec_t v[8], input int cnt);
      logic [31:0] res;
      int lat, nd;
      for (int i = 0; i < cnt; i++) begin
         issue_and_wait(v[i].a, v[i].b, v[i].op, res, lat, nd);
         checks++;
         if (res !== v[i].r) begin
            errors++;
            $display("FAIL %s[%0d] result got %h want %h", tag, i, res, v[i].r);
         end
         checks++;
         if (lat != 5 || nd != 1) begin
            errors++;
            $display("FAIL %s[%0d] timing latency %0d dones %0d want 5 and 1", tag, i, lat, nd);
         end
      end
   endtask

   task automatic test_arith();
      vec_t v[8];
      v[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000};
      v[1] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
      v[2] = '{32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000};
      v[3] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000};
      v[4] = '{32'h41200000, 32'h3F000000, 1'b0, 32'h41280000};
      v[5] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
      v[6] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000};
      v[7] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000};
      run_table("arith", v, 8);
   endtask

   task automatic test_rounding();
      vec_t v[8];
      v[0] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
      v[1] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};
      v[2] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000};
      v[3] = '{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB};
      v[4] = '{32'hC0490FDB, 32'h80000000, 1'b0, 32'hC0490FDB};
      v[5] = '{32'h80000000, 32'h40490FDB, 1'b0, 32'h40490FDB};
      v[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
      v[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
      run_table("round_zero", v, 6);
   endtask

   task automatic test_specials();
      vec_t v[8];
      v[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
      v[1] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};
      v[2] = '{32'h00400000, 32'h80000000, 1'b0, 32'h00000000};
      v[3] = '{32'hFFC00123, 32'h3F800000, 1'b0, 32'h7FC00000};
      v[4] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000};
      v[5] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000};
      v[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
      v[7] = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000};
      run_table("special", v, 8);
   endtask

   task automatic test_stall_hold();
      dataa = 32'h3F800000; datab = 32'h40000000; n = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL stall_early_done got %b want 0", done); end
      tick();
      checks++;
      if (done !== 1'b1 || result !== 32'h40400000) begin
         errors++; $display("FAIL stall_done got %b %h want 1 40400000", done, result);
      end
      clk_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (done !== 1'b1 || result !== 32'h40400000) begin
            errors++; $display("FAIL stall_hold[%0d] got %b %h want 1 40400000", i, done, result);
         end
      end
      clk_en = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || result !== 32'h40400000) begin
         errors++; $display("FAIL stall_release got %b %h want 0 40400000", done, result);
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[8];
      int issue_cyc[8], done_cyc[8], exp_lat;
      logic [31:0] got[8];
      int idx, nd;
      logic en_now, issued;
      v[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
      v[1] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
      v[2] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000};
      v[3] = '{32'h41200000, 32'h3F000000, 1'b0, 32'h41280000};
      v[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
      v[5] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
      v[6] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000};
      v[7] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000};
      idx = 0; nd = 0;
      for (int c = 0; c < 30; c++) begin
         clk_en = !(c == 4 || c == 5);
         if (idx < 8 && clk_en) begin
            dataa = v[idx].a; datab = v[idx].b; n = v[idx].op; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         en_now = clk_en;
         issued = start;
         tick();
         if (issued && en_now) begin
            issue_cyc[idx] = c;
            idx++;
         end
         if (en_now && done === 1'b1) begin
            if (nd < 8) begin
               got[nd] = result;
               done_cyc[nd] = c;
            end
            nd++;
         end
      end
      start = 1'b0; clk_en = 1'b1;
      checks++;
      if (nd != 8) begin errors++; $display("FAIL b2b_done_count got %0d want 8", nd); end
      for (int i = 0; i < 8 && i < nd; i++) begin
         exp_lat = (i < 4) ? 7 : 5;
         checks++;
         if (got[i] !== v[i].r) begin
            errors++; $display("FAIL b2b[%0d] result got %h want %h", i, got[i], v[i].r);
         end
         checks++;
         if (done_cyc[i] - issue_cyc[i] != exp_lat) begin
            errors++;
            $display("FAIL b2b[%0d] latency got %0d want %0d", i, done_cyc[i] - issue_cyc[i], exp_lat);
         end
      end
   endtask

   task automatic test_reset_flush();
      logic [31:0] res;
      int lat, nd;
      int spurious;
      spurious = 0;
      n = 1'b0; start = 1'b1;
      dataa = 32'h3F800000; datab = 32'h3F800000; tick();
      dataa = 32'h40000000; datab = 32'h3F800000; tick();
      dataa = 32'h41200000; datab = 32'h3F000000; tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (done !== 1'b0 || result !== 32'h0) begin
         errors++; $display("FAIL flush_at_reset got %b %h want 0 00000000", done, result);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin errors++; $display("FAIL flush_no_done got %0d dones want 0", spurious); end
      checks++;
      if (result !== 32'h0) begin errors++; $display("FAIL flush_result got %h want 00000000", result); end
      issue_and_wait(32'h40000000, 32'h40000000, 1'b0, res, lat, nd);
      checks++;
      if (res !== 32'h40800000 || lat != 5 || nd != 1) begin
         errors++;
         $display("FAIL flush_reissue got %h lat %0d dones %0d want 40800000 5 1", res, lat, nd);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_arith();
      test_rounding();
      test_specials();
      test_stall_hold();
      test_back_to_back();
      test_reset_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
